// File: rtl/uart_word_pkg.sv
// Shared types and helpers for the UART multi-word detector.
// Provides the FSM state encoding, ASCII upper-case folding and width helpers.
package uart_word_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // 3 s at 50 MHz.
  localparam int unsigned HOLD_CYCLES_3S = 150_000_000;

  function automatic logic [7:0] fold_upper(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7a) begin
      return c - 8'h20;
    end
    return c;
  endfunction

  // $clog2 that never returns less than one bit.
  function automatic int unsigned width_min1(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_multi_word_detector_hold_timer.sv
// Hold-window down-counter: loaded with HOLD_CYCLES on start.
// Ports: clk, rst (async high), start in; busy (count running), done (1-cycle expiry) out.
module hold_timer
  import uart_word_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_3S
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int unsigned CW = width_min1(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(HOLD_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);
  // Count value 1 marks the last hold cycle.
  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/uart_multi_word_detector.sv
// Streaming detector of up to N_WORDS programmable words on the UART rx byte path.
// Ports: rx_valid/rx_data bytes, cfg_* pattern/length writes, match_valid/match_id,
// hold_active window flag, cnt_sel/hit_count per-slot saturating hit counters.
module uart_multi_word_detector
  import uart_word_pkg::*;
#(
  parameter int          N_WORDS     = 4,
  parameter int          MAX_LEN     = 8,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_3S,
  parameter int          CASE_FOLD   = 1,
  parameter int          CNT_W       = 8,
  localparam int         LEN_W       = $clog2(MAX_LEN + 1),
  localparam int         IDX_W       = $clog2(MAX_LEN),
  localparam int         ID_W        = width_min1(N_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             cfg_we,
  input  logic [ID_W-1:0]  cfg_slot,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [7:0]       cfg_char,
  input  logic             cfg_len_we,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             match_valid,
  output logic [ID_W-1:0]  match_id,
  output logic             hold_active,
  input  logic [ID_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0] hit_count
);

  state_e state_q, state_d;

  logic [N_WORDS-1:0][MAX_LEN-1:0][7:0] word_q, word_d;
  logic [N_WORDS-1:0][LEN_W-1:0]        len_q, len_d;
  logic [N_WORDS-1:0][IDX_W-1:0]        prog_q, prog_d;
  logic [N_WORDS-1:0][CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_WORDS-1:0]                   hit;

  logic             mv_q, mv_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [7:0]       rx_c, cfg_c;
  logic [LEN_W-1:0] len_clamped;
  logic             cfg_any, accept, slot_ok, idx_ok;
  logic             go_hold, tmr_busy, tmr_done;

  assign rx_c  = (CASE_FOLD != 0) ? fold_upper(rx_data) : rx_data;
  assign cfg_c = (CASE_FOLD != 0) ? fold_upper(cfg_char) : cfg_char;

  assign cfg_any = cfg_we | cfg_len_we;
  // A config write in the same cycle steals the byte.
  assign accept  = rx_valid && (state_q == ST_IDLE) && !cfg_any;
  assign slot_ok = (int'(cfg_slot) < N_WORDS);
  assign idx_ok  = (int'(cfg_idx) < MAX_LEN);
  assign len_clamped =
    (int'(cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;
  assign go_hold = (|hit) && (HOLD_CYCLES != 0);

  // Restart-on-mismatch: a miss only re-checks the first character.
  always_comb begin
    prog_d = prog_q;
    hit    = '0;
    if (accept) begin
      for (int s = 0; s < N_WORDS; s++) begin
        if (len_q[s] != '0) begin
          if (rx_c == word_q[s][prog_q[s]]) begin
            if (LEN_W'(prog_q[s]) + LEN_W'(1) == len_q[s]) begin
              hit[s] = 1'b1;
            end else begin
              prog_d[s] = prog_q[s] + IDX_W'(1);
            end
          end else if (rx_c == word_q[s][0]) begin
            prog_d[s] = IDX_W'(1);
          end else begin
            prog_d[s] = '0;
          end
        end
      end
    end
    if ((|hit) || (state_q == ST_HOLD)) begin
      prog_d = '0;
    end
    if (cfg_any && slot_ok) begin
      prog_d[cfg_slot] = '0;
    end
  end

  // Descending scan so the lowest hitting slot ends up in id_d.
  always_comb begin
    cnt_d = cnt_q;
    mv_d  = |hit;
    id_d  = id_q;
    for (int s = N_WORDS - 1; s >= 0; s--) begin
      if (hit[s]) begin
        id_d = ID_W'(s);
        if (cnt_q[s] != '1) begin
          cnt_d[s] = cnt_q[s] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    word_d = word_q;
    len_d  = len_q;
    if (cfg_we && slot_ok && idx_ok) begin
      word_d[cfg_slot][cfg_idx] = cfg_c;
    end
    if (cfg_len_we && slot_ok) begin
      len_d[cfg_slot] = len_clamped;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      len_q  <= '0;
      prog_q <= '0;
      cnt_q  <= '0;
      mv_q   <= 1'b0;
      id_q   <= '0;
    end else begin
      word_q <= word_d;
      len_q  <= len_d;
      prog_q <= prog_d;
      cnt_q  <= cnt_d;
      mv_q   <= mv_d;
      id_q   <= id_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (go_hold)  state_d = ST_HOLD;
      ST_HOLD: if (tmr_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hold_active = (state_q == ST_HOLD) && tmr_busy;
  end

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .start(go_hold),
    .busy (tmr_busy),
    .done (tmr_done)
  );

  assign match_valid = mv_q;
  assign match_id    = id_q;

  always_comb begin
    hit_count = '0;
    if (int'(cnt_sel) < N_WORDS) begin
      hit_count = cnt_q[cnt_sel];
    end
  end

endmodule

// File: tb/tb_uart_multi_word_detector.sv
// Bench for uart_multi_word_detector: instance 0 has a 20-cycle hold,
// instance 1 has no hold; a behavioural model tracks both.
module tb_uart_multi_word_detector;

  localparam int NW  = 4;
  localparam int ML  = 8;
  localparam int CW  = 8;
  localparam int LW  = $clog2(ML + 1);
  localparam int IW  = $clog2(ML);
  localparam int IDW = 2;
  localparam int HC0 = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           rx_valid   [2];
  logic [7:0]     rx_data    [2];
  logic           cfg_we     [2];
  logic [IDW-1:0] cfg_slot   [2];
  logic [IW-1:0]  cfg_idx    [2];
  logic [7:0]     cfg_char   [2];
  logic           cfg_len_we [2];
  logic [LW-1:0]  cfg_len    [2];
  logic           mv         [2];
  logic [IDW-1:0] mid        [2];
  logic           hold       [2];
  logic [IDW-1:0] sel        [2];
  logic [CW-1:0]  hc         [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_multi_word_detector #(
      .N_WORDS    (NW),
      .MAX_LEN    (ML),
      .HOLD_CYCLES((g == 0) ? HC0 : 0),
      .CASE_FOLD  (1),
      .CNT_W      (CW)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid[g]),
      .rx_data    (rx_data[g]),
      .cfg_we     (cfg_we[g]),
      .cfg_slot   (cfg_slot[g]),
      .cfg_idx    (cfg_idx[g]),
      .cfg_char   (cfg_char[g]),
      .cfg_len_we (cfg_len_we[g]),
      .cfg_len    (cfg_len[g]),
      .match_valid(mv[g]),
      .match_id   (mid[g]),
      .hold_active(hold[g]),
      .cnt_sel    (sel[g]),
      .hit_count  (hc[g])
    );
  end

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  logic [7:0] m_word [2][NW][ML];
  int         m_len  [2][NW];
  int         m_prog [2][NW];
  int         m_cnt  [2][NW];
  int         m_left [2];
  int         m_id   [2];
  logic       m_mv   [2];

  function automatic logic [7:0] up(input logic [7:0] c);
    return (c >= "a" && c <= "z") ? c - 8'd32 : c;
  endfunction

  function automatic int hold_len(input int k);
    return (k == 0) ? HC0 : 0;
  endfunction

  task automatic model_clear(input int k);
    for (int s = 0; s < NW; s++) begin
      for (int i = 0; i < ML; i++) m_word[k][s][i] = 8'h00;
      m_len[k][s]  = 0;
      m_prog[k][s] = 0;
      m_cnt[k][s]  = 0;
    end
    m_left[k] = 0;
    m_id[k]   = 0;
    m_mv[k]   = 1'b0;
  endtask

  task automatic model_step(input int k);
    logic [7:0] c;
    int hits;
    bit acc;
    if (rst) begin
      model_clear(k);
      return;
    end
    acc  = rx_valid[k] && m_left[k] == 0 && !cfg_we[k] && !cfg_len_we[k];
    hits = 0;
    m_mv[k] = 1'b0;
    if (acc) begin
      c = up(rx_data[k]);
      for (int s = 0; s < NW; s++) begin
        if (m_len[k][s] > 0) begin
          if (c == m_word[k][s][m_prog[k][s]]) begin
            m_prog[k][s]++;
            if (m_prog[k][s] == m_len[k][s]) hits |= (1 << s);
          end else if (c == m_word[k][s][0]) begin
            m_prog[k][s] = 1;
          end else begin
            m_prog[k][s] = 0;
          end
        end
      end
    end
    if (hits != 0) begin
      m_mv[k] = 1'b1;
      for (int s = NW - 1; s >= 0; s--) begin
        if (hits[s]) begin
          m_id[k] = s;
          if (m_cnt[k][s] < 255) m_cnt[k][s]++;
        end
      end
      for (int s = 0; s < NW; s++) m_prog[k][s] = 0;
      m_left[k] = hold_len(k);
    end else if (m_left[k] > 0) begin
      m_left[k]--;
    end
    if (cfg_we[k]) begin
      m_word[k][cfg_slot[k]][cfg_idx[k]] = up(cfg_char[k]);
      m_prog[k][cfg_slot[k]] = 0;
    end
    if (cfg_len_we[k]) begin
      m_len[k][cfg_slot[k]] = (int'(cfg_len[k]) > ML) ? ML : int'(cfg_len[k]);
      m_prog[k][cfg_slot[k]] = 0;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] c);
    rx_valid[k] = 1'b1;
    rx_data[k]  = c;
    tick();
    rx_valid[k] = 1'b0;
  endtask

  task automatic send_str(input int k, input string s);
    for (int i = 0; i < s.len(); i++) send(k, s[i]);
  endtask

  task automatic wr_char(input int k, input int slot, input int idx,
                         input logic [7:0] ch);
    cfg_we[k]   = 1'b1;
    cfg_slot[k] = IDW'(slot);
    cfg_idx[k]  = IW'(idx);
    cfg_char[k] = ch;
    tick();
    cfg_we[k] = 1'b0;
  endtask

  task automatic wr_len(input int k, input int slot, input int len);
    cfg_len_we[k] = 1'b1;
    cfg_slot[k]   = IDW'(slot);
    cfg_len[k]    = LW'(len);
    tick();
    cfg_len_we[k] = 1'b0;
  endtask

  task automatic prog_word(input int k, input int slot, input string s,
                           input int len);
    for (int i = 0; i < s.len(); i++) wr_char(k, slot, i, s[i]);
    wr_len(k, slot, len);
  endtask

  task automatic wait_idle(input int k, input string tag);
    int n = 0;
    while (hold[k] === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_total++;
    if (hold[k] !== 1'b0) $display("FAIL %s_timeout hold=%b exp=0", tag, hold[k]);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rx_valid[k] = 0; rx_data[k] = 0; cfg_we[k] = 0; cfg_slot[k] = 0;
      cfg_idx[k] = 0; cfg_char[k] = 0; cfg_len_we[k] = 0; cfg_len[k] = 0;
      sel[k] = 0;
    end
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (mv[k] !== 1'b0) $display("FAIL reset_mv%0d got=%b exp=0", k, mv[k]);
      else n_pass++;
      n_total++;
      if (mid[k] !== 2'd0) $display("FAIL reset_id%0d got=%0d exp=0", k, mid[k]);
      else n_pass++;
      n_total++;
      if (hold[k] !== 1'b0) $display("FAIL reset_hold%0d got=%b exp=0", k, hold[k]);
      else n_pass++;
    end
    for (int s = 0; s < NW; s++) begin
      sel[0] = IDW'(s);
      #1;
      n_total++;
      if (hc[0] !== 8'd0) $display("FAIL reset_cnt%0d got=%0d exp=0", s, hc[0]);
      else n_pass++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n;
    prog_word(0, 0, "HELLO", 5);
    send_str(0, "HELL");
    n_total++;
    if (mv[0] !== 1'b0) $display("FAIL single_early_mv got=%b exp=0", mv[0]);
    else n_pass++;
    send(0, "O");
    n_total++;
    if (mv[0] !== 1'b1) $display("FAIL single_mv got=%b exp=1", mv[0]);
    else n_pass++;
    n_total++;
    if (mid[0] !== 2'd0) $display("FAIL single_id got=%0d exp=0", mid[0]);
    else n_pass++;
    n_total++;
    if (hold[0] !== 1'b1) $display("FAIL single_hold got=%b exp=1", hold[0]);
    else n_pass++;
    sel[0] = 0;
    #1;
    n_total++;
    if (hc[0] !== 8'd1) $display("FAIL single_cnt got=%0d exp=1", hc[0]);
    else n_pass++;
    tick();
    n_total++;
    if (mv[0] !== 1'b0) $display("FAIL single_pulse got=%b exp=0", mv[0]);
    else n_pass++;
    n = 1;
    while (hold[0] === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    n_total++;
    if (n != HC0) $display("FAIL single_hold_len got=%0d exp=%0d", n, HC0);
    else n_pass++;
  endtask

  task automatic test_restart();
    send_str(0, "HHELLO");
    n_total++;
    if (mv[0] !== 1'b1) $display("FAIL restart_hh got=%b exp=1", mv[0]);
    else n_pass++;
    wait_idle(0, "restart1");
    send_str(0, "HEXHELLO");
    n_total++;
    if (mv[0] !== 1'b1) $display("FAIL restart_hex got=%b exp=1", mv[0]);
    else n_pass++;
    sel[0] = 0;
    #1;
    n_total++;
    if (hc[0] !== 8'd3) $display("FAIL restart_cnt got=%0d exp=3", hc[0]);
    else n_pass++;
    wait_idle(0, "restart2");
  endtask

  task automatic test_fold_prio();
    prog_word(0, 1, "go", 2);
    prog_word(0, 3, "GO", 2);
    send_str(0, "Go");
    n_total++;
    if (mv[0] !== 1'b1 || mid[0] !== 2'd1)
      $display("FAIL prio mv/id got=%b/%0d exp=1/1", mv[0], mid[0]);
    else n_pass++;
    sel[0] = 1;
    #1;
    n_total++;
    if (hc[0] !== 8'd1) $display("FAIL prio_cnt1 got=%0d exp=1", hc[0]);
    else n_pass++;
    sel[0] = 3;
    #1;
    n_total++;
    if (hc[0] !== 8'd1) $display("FAIL prio_cnt3 got=%0d exp=1", hc[0]);
    else n_pass++;
    wait_idle(0, "prio");
  endtask

  task automatic test_hold();
    string w = "HELLO";
    prog_word(0, 2, "Z", 1);
    send_str(0, w);
    n_total++;
    if (mv[0] !== 1'b1) $display("FAIL hold_first got=%b exp=1", mv[0]);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      send(0, w[i]);
      n_total++;
      if (mv[0] !== 1'b0) $display("FAIL hold_ignore%0d got=%b exp=0", i, mv[0]);
      else n_pass++;
    end
    sel[0] = 0;
    #1;
    n_total++;
    if (hc[0] !== 8'd4) $display("FAIL hold_cnt got=%0d exp=4", hc[0]);
    else n_pass++;
    repeat (14) tick();
    n_total++;
    if (hold[0] !== 1'b1) $display("FAIL hold_last got=%b exp=1", hold[0]);
    else n_pass++;
    send(0, "Z");
    n_total++;
    if (mv[0] !== 1'b0 || hold[0] !== 1'b0)
      $display("FAIL hold_drop mv/hold got=%b/%b exp=0/0", mv[0], hold[0]);
    else n_pass++;
    send(0, "Z");
    n_total++;
    if (mv[0] !== 1'b1 || mid[0] !== 2'd2)
      $display("FAIL hold_accept mv/id got=%b/%0d exp=1/2", mv[0], mid[0]);
    else n_pass++;
    wait_idle(0, "hold");
  endtask

  task automatic test_clamp_len0();
    prog_word(0, 2, "ABCDEFGH", 15);
    send_str(0, "ABCDEFGH");
    n_total++;
    if (mv[0] !== 1'b1 || mid[0] !== 2'd2)
      $display("FAIL clamp mv/id got=%b/%0d exp=1/2", mv[0], mid[0]);
    else n_pass++;
    wait_idle(0, "clamp");
    wr_len(0, 2, 0);
    send_str(0, "ABCDEFGH");
    n_total++;
    if (mv[0] !== 1'b0) $display("FAIL len0 got=%b exp=0", mv[0]);
    else n_pass++;
    sel[0] = 2;
    #1;
    n_total++;
    if (hc[0] !== 8'd2) $display("FAIL len0_cnt got=%0d exp=2", hc[0]);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    send_str(0, "HEL");
    rst = 1'b1;
    sel[0] = 0;
    #1;
    n_total++;
    if (mv[0] !== 1'b0 || mid[0] !== 2'd0 || hold[0] !== 1'b0)
      $display("FAIL rst_outs mv/id/hold got=%b/%0d/%b exp=0/0/0",
               mv[0], mid[0], hold[0]);
    else n_pass++;
    n_total++;
    if (hc[0] !== 8'd0) $display("FAIL rst_cnt got=%0d exp=0", hc[0]);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    send_str(0, "LOHELLO");
    n_total++;
    if (mv[0] !== 1'b0) $display("FAIL rst_disabled got=%b exp=0", mv[0]);
    else n_pass++;
  endtask

  task automatic test_rewrite();
    prog_word(0, 0, "HELLO", 5);
    send_str(0, "HEL");
    wr_char(0, 0, 3, "L");
    send_str(0, "LO");
    n_total++;
    if (mv[0] !== 1'b0) $display("FAIL rewrite_nohit got=%b exp=0", mv[0]);
    else n_pass++;
    send_str(0, "HELLO");
    n_total++;
    if (mv[0] !== 1'b1) $display("FAIL rewrite_hit got=%b exp=1", mv[0]);
    else n_pass++;
    wait_idle(0, "rewrite");
  endtask

  task automatic test_back_to_back();
    prog_word(1, 0, "A", 1);
    for (int i = 0; i < 3; i++) begin
      send(1, "A");
      n_total++;
      if (mv[1] !== 1'b1 || hold[1] !== 1'b0)
        $display("FAIL b2b%0d mv/hold got=%b/%b exp=1/0", i, mv[1], hold[1]);
      else n_pass++;
    end
    send(1, "a");
    n_total++;
    if (mv[1] !== 1'b1) $display("FAIL b2b_fold got=%b exp=1", mv[1]);
    else n_pass++;
    send(1, "B");
    n_total++;
    if (mv[1] !== 1'b0) $display("FAIL b2b_miss got=%b exp=0", mv[1]);
    else n_pass++;
    sel[1] = 0;
    #1;
    n_total++;
    if (hc[1] !== 8'd4) $display("FAIL b2b_cnt got=%0d exp=4", hc[1]);
    else n_pass++;
    repeat (296) send(1, "A");
    n_total++;
    if (hc[1] !== 8'd255) $display("FAIL sat_cnt got=%0d exp=255", hc[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    string alpha = "HELOhelo";
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < NW; s++) begin
        int len = int'($urandom_range(1, 4));
        for (int i = 0; i < len; i++)
          wr_char(k, s, i, alpha[$urandom_range(0, 7)]);
        wr_len(k, s, len);
      end
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        rx_valid[k]   = ($urandom_range(0, 99) < 70);
        rx_data[k]    = alpha[$urandom_range(0, 7)];
        cfg_len_we[k] = ($urandom_range(0, 99) < 3);
        cfg_slot[k]   = IDW'($urandom_range(0, NW - 1));
        cfg_len[k]    = LW'($urandom_range(0, 15));
        sel[k]        = IDW'($urandom_range(0, NW - 1));
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        rx_valid[k]   = 1'b0;
        cfg_len_we[k] = 1'b0;
        n_total++;
        if (mv[k] !== m_mv[k] || mid[k] !== IDW'(m_id[k]) ||
            hold[k] !== (m_left[k] > 0) ||
            hc[k] !== CW'(m_cnt[k][sel[k]]))
          $display("FAIL rand k%0d cyc%0d mv/id/hold/cnt got=%b/%0d/%b/%0d exp=%b/%0d/%b/%0d",
                   k, cyc, mv[k], mid[k], hold[k], hc[k],
                   m_mv[k], m_id[k], m_left[k] > 0, m_cnt[k][sel[k]]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_restart();
    test_fold_prio();
    test_hold();
    test_clamp_len0();
    test_mid_reset();
    test_rewrite();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim_time exceeded passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
